// File: rtl/snoop_bus_arbiter_if.sv
// Snooping-bus interface shared by the arbiter, the caches and main memory.
// The master modport is the arbiter's view. The slave modport is the
// caches/memory view.
// SNOOP_ARB_TIMEOUT_EN adds the error timeout pulse.
interface snoop_bus_if #(
  parameter int N      = 4,
  parameter int ADDR_W = 8
);
  logic [N-1:0]        req;
  logic [2*N-1:0]      reqCmd;
  logic [N*ADDR_W-1:0] reqAddr;
  logic [N-1:0]        ownerModified;
  logic                memAck;
  logic [N-1:0]        grant;
  logic [N-1:0]        done;
  logic                snoopValid;
  logic [1:0]          snoopCmd;
  logic [ADDR_W-1:0]   snoopAddr;
  logic [N-1:0]        fetch;
  logic [N-1:0]        invalidate;
  logic                memReq;
  logic                memWrite;
  logic [ADDR_W-1:0]   memAddr;
`ifdef SNOOP_ARB_TIMEOUT_EN
  logic                error;

  modport master (
    input  req, reqCmd, reqAddr, ownerModified, memAck,
    output grant, done, snoopValid, snoopCmd, snoopAddr, fetch, invalidate,
           memReq, memWrite, memAddr, error
  );
  modport slave (
    output req, reqCmd, reqAddr, ownerModified, memAck,
    input  grant, done, snoopValid, snoopCmd, snoopAddr, fetch, invalidate,
           memReq, memWrite, memAddr, error
  );
`else
  modport master (
    input  req, reqCmd, reqAddr, ownerModified, memAck,
    output grant, done, snoopValid, snoopCmd, snoopAddr, fetch, invalidate,
           memReq, memWrite, memAddr
  );
  modport slave (
    output req, reqCmd, reqAddr, ownerModified, memAck,
    input  grant, done, snoopValid, snoopCmd, snoopAddr, fetch, invalidate,
           memReq, memWrite, memAddr
  );
`endif
endinterface

// File: rtl/snoop_bus_arbiter.sv
// Round-robin arbiter for a snooping MSI bus.
// A bus transaction runs through these states:
// IDLE -> SNOOP -> [WBACK] -> [FILL] -> DONE.
// Optional feature: SNOOP_ARB_TIMEOUT_EN adds an 8-bit memory watchdog.
// When the watchdog fires, the transaction is forced to DONE and error is pulsed.
module snoop_bus_arbiter #(
  parameter int N      = 4,
  parameter int ADDR_W = 8
) (
  input  logic          clock_i,
  input  logic          reset_i,
  snoop_bus_if.master   bus
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SNOOP, ST_WBACK, ST_FILL, ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    winner_q, winner_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [1:0]          cmd_q, cmd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;

  logic [N-1:0]        valid;
  logic [N-1:0]        winner_oh;
  logic [N-1:0]        fetch_w;
  logic                pick_found;
  logic [IDX_W-1:0]    pick_idx;
  logic [IDX_W-1:0]    cand;
  logic                fetch_cmd;
  logic                inval_cmd;

`ifdef SNOOP_ARB_TIMEOUT_EN
  logic [7:0]          wd_q, wd_d;
  logic                tmo_q, tmo_d;
`endif

  // A request only counts when it carries a real command.
  // The winner index is also decoded to a one-hot vector.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      assign valid[gi]     = bus.req[gi] & (bus.reqCmd[2*gi+1 -: 2] != 2'b00);
      assign winner_oh[gi] = (winner_q == IDX_W'(gi));
    end
  endgenerate

  // Round-robin search upward from the cache after lastGrant, wrapping modulo N.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last_q;
    cand       = last_q;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(last_q) + k) % N);
      if (!pick_found && valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Snoop strobes: fetch a Modified line away from a non-requester on read/write miss.
  // Invalidate sharers on write miss or upgrade.
  assign fetch_cmd = (cmd_q == 2'b01) || (cmd_q == 2'b10);
  assign inval_cmd = (cmd_q == 2'b10) || (cmd_q == 2'b11);
  assign fetch_w   = (state_q == ST_SNOOP && fetch_cmd) ? (bus.ownerModified & ~winner_oh) : '0;

  assign bus.grant      = (state_q != ST_IDLE) ? winner_oh : '0;
  assign bus.done       = (state_q == ST_DONE) ? winner_oh : '0;
  assign bus.snoopValid = (state_q == ST_SNOOP);
  assign bus.snoopCmd   = cmd_q;
  assign bus.snoopAddr  = addr_q;
  assign bus.fetch      = fetch_w;
  assign bus.invalidate = (state_q == ST_SNOOP && inval_cmd) ? ~winner_oh : '0;
  assign bus.memReq     = (state_q == ST_WBACK) || (state_q == ST_FILL);
  assign bus.memWrite   = (state_q == ST_WBACK);
  assign bus.memAddr    = addr_q;
`ifdef SNOOP_ARB_TIMEOUT_EN
  assign bus.error      = (state_q == ST_DONE) & tmo_q;
`endif

  // Next-state logic: transaction sequencing and winner latching.
  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    last_d   = last_q;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
`ifdef SNOOP_ARB_TIMEOUT_EN
    wd_d     = 8'd0;
    tmo_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          winner_d = pick_idx;
          cmd_d    = bus.reqCmd[{pick_idx, 1'b0} +: 2];
          addr_d   = bus.reqAddr[pick_idx*ADDR_W +: ADDR_W];
          state_d  = ST_SNOOP;
        end
      end
      ST_SNOOP: begin
        if (|fetch_w)              state_d = ST_WBACK;
        else if (cmd_q == 2'b11)   state_d = ST_DONE;
        else                       state_d = ST_FILL;
      end
      ST_WBACK, ST_FILL: begin
        if (bus.memAck) begin
          state_d = (state_q == ST_WBACK) ? ST_FILL : ST_DONE;
        end
`ifdef SNOOP_ARB_TIMEOUT_EN
        else if (wd_q == 8'd254) begin
          state_d = ST_DONE;
          tmo_d   = 1'b1;
        end else begin
          wd_d = wd_q + 8'd1;
        end
`endif
      end
      ST_DONE: begin
        last_d  = winner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latch registers with synchronous reset.
  // After reset, cache 0 has first priority.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      winner_q <= '0;
      last_q   <= IDX_W'(N - 1);
      cmd_q    <= 2'b00;
      addr_q   <= '0;
`ifdef SNOOP_ARB_TIMEOUT_EN
      wd_q     <= 8'd0;
      tmo_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      last_q   <= last_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
`ifdef SNOOP_ARB_TIMEOUT_EN
      wd_q     <= wd_d;
      tmo_q    <= tmo_d;
`endif
    end
  end
endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Scoreboard bench for snoop_bus_arbiter.
// The driver predicts each transaction and queues the prediction.
// The monitor checks DUT activity against the queue head.
// A memory responder acks after per-transaction delays.
module tb_snoop_bus_arbiter;
  localparam int N      = 4;
  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  snoop_bus_if #(.N(N), .ADDR_W(ADDR_W)) bus ();
  snoop_bus_arbiter #(.N(N), .ADDR_W(ADDR_W)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  typedef struct {
    logic [N-1:0]      gnt;
    logic [1:0]        cmd;
    logic [ADDR_W-1:0] addr;
    logic [N-1:0]      fetch;
    logic [N-1:0]      inv;
    bit                wb;
    int                wd;
    int                fd;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int snoop_cyc = 0;
  int model_last = N - 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Monitor: compares snoop, memory and done activity against the queue head.
  exp_t mon_e;
  int   mon_lat;
  bit   mon_w;
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (bus.snoopValid) begin
        if (exp_q.size() == 0) check("snoop_unexpected", 32'(bus.snoopValid), 32'd0);
        else begin
          mon_e = exp_q[0];
          check("snoop_grant", 32'(bus.grant), 32'(mon_e.gnt));
          check("snoop_cmd",   32'(bus.snoopCmd), 32'(mon_e.cmd));
          check("snoop_addr",  32'(bus.snoopAddr), 32'(mon_e.addr));
          check("snoop_fetch", 32'(bus.fetch), 32'(mon_e.fetch));
          check("snoop_inval", 32'(bus.invalidate), 32'(mon_e.inv));
          snoop_cyc = cyc;
          $display("snoop: grant=%b cmd=%b addr=%0h fetch=%b inv=%b",
                   bus.grant, bus.snoopCmd, bus.snoopAddr, bus.fetch, bus.invalidate);
        end
      end else begin
        check("fetch_quiet", 32'(bus.fetch), 32'd0);
        check("inval_quiet", 32'(bus.invalidate), 32'd0);
      end
      if (bus.memReq && exp_q.size() > 0) begin
        mon_e = exp_q[0];
        mon_w = mon_e.wb && ((cyc - snoop_cyc) <= mon_e.wd + 1);
        check("mem_write", 32'(bus.memWrite), 32'(mon_w));
        check("mem_addr",  32'(bus.memAddr), 32'(mon_e.addr));
        check("mem_grant", 32'(bus.grant), 32'(mon_e.gnt));
      end
      if (bus.done != '0) begin
        if (exp_q.size() == 0) check("done_unexpected", 32'(bus.done), 32'd0);
        else begin
          mon_e = exp_q.pop_front();
          mon_lat = 1 + (mon_e.wb ? mon_e.wd + 1 : 0) + ((mon_e.cmd != 2'b11) ? mon_e.fd + 1 : 0);
          check("done_vec", 32'(bus.done), 32'(mon_e.gnt));
          check("done_latency", 32'(cyc - snoop_cyc), 32'(mon_lat));
          $display("done: done=%b latency=%0d expected=%0d", bus.done, cyc - snoop_cyc, mon_lat);
        end
      end
    end
  end

  // Memory responder: acks after the queued delay in each phase.
  // It toggles memAck randomly while no request is pending.
  bit prev_req = 1'b0;
  bit prev_w = 1'b0;
  int mcnt = 0;
  int tgt = 0;
  always @(negedge clk) begin
    if (bus.memReq) begin
      if (!prev_req || (bus.memWrite != prev_w)) mcnt = 0;
      else mcnt++;
      tgt = (exp_q.size() > 0) ? (bus.memWrite ? exp_q[0].wd : exp_q[0].fd) : 0;
      bus.memAck = (mcnt == tgt);
    end else begin
      bus.memAck = 1'($urandom_range(0, 1));
    end
    prev_req = bus.memReq;
    prev_w   = bus.memWrite;
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    model_last = N - 1;
    rst = 1'b0;
  endtask

  // Issue one stimulus pattern, predict its transaction, then wait for completion.
  task automatic issue(input logic [N-1:0] r, input logic [2*N-1:0] c,
                       input logic [N*ADDR_W-1:0] a, input logic [N-1:0] om,
                       input int wd, input int fd, input bit drop);
    int   win;
    exp_t e;
    bit   ok;
    win = -1;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (model_last + k) % N;
      if (win < 0 && r[i] && (c[2*i +: 2] != 2'b00)) win = i;
    end
    if (win >= 0) begin
      e.gnt = '0;
      e.gnt[win] = 1'b1;
      e.cmd   = c[2*win +: 2];
      e.addr  = a[win*ADDR_W +: ADDR_W];
      e.inv   = (e.cmd == 2'b10 || e.cmd == 2'b11) ? ~e.gnt : '0;
      e.fetch = (e.cmd == 2'b01 || e.cmd == 2'b10) ? (om & ~e.gnt) : '0;
      e.wb    = |e.fetch;
      e.wd    = wd;
      e.fd    = fd;
      exp_q.push_back(e);
      model_last = win;
    end
    bus.req = r;
    bus.reqCmd = c;
    bus.reqAddr = a;
    bus.ownerModified = om;
    if (win < 0) begin
      repeat (4) begin
        @(negedge clk);
        check("idle_grant", 32'(bus.grant), 32'd0);
      end
      return;
    end
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (drop && bus.snoopValid) bus.req = '0;
      if (bus.done != '0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("done_timeout", 32'(ok), 32'd1);
      exp_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    bit ok;
    bus.req = '0;
    bus.reqCmd = '0;
    bus.reqAddr = '0;
    bus.ownerModified = '0;
    bus.memAck = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_grant",    32'(bus.grant), 32'd0);
    check("rst_done",     32'(bus.done), 32'd0);
    check("rst_snoop",    32'(bus.snoopValid), 32'd0);
    check("rst_memreq",   32'(bus.memReq), 32'd0);
    check("rst_memwrite", 32'(bus.memWrite), 32'd0);
    check("rst_memaddr",  32'(bus.memAddr), 32'd0);
    check("rst_snoopcmd", 32'(bus.snoopCmd), 32'd0);
    rst = 1'b0;

    // Read miss by cache 0, with no owner and an immediate fill ack.
    issue(4'b0001, 8'b0000_0001, 32'h0000_005A, 4'b0000, 0, 0, 1'b0);

    // All caches request an upgrade: round-robin order starting at cache 0.
    do_reset();
    repeat (5) issue(4'b1111, 8'hFF, 32'h44332211, 4'b0000, 0, 0, 1'b0);

    // Write miss by cache 1, with cache 2 holding the line Modified.
    issue(4'b0010, 8'b0000_1000, 32'h00007700, 4'b0100, 1, 1, 1'b0);

    // The requester's own ownerModified bit is ignored, so there is a direct fill.
    issue(4'b0001, 8'b0000_0001, 32'h000000C3, 4'b0001, 0, 2, 1'b0);

    // Multiple owners flagged: fetch all flagged caches, with a single write-back.
    issue(4'b1000, 8'b0100_0000, 32'hE1000000, 4'b0111, 2, 0, 1'b0);

    // Reset while a fill is waiting on memory.
    do_reset();
    issue(4'b0010, 8'b0000_0100, 32'h00003300, 4'b0000, 0, 0, 1'b0);
    begin
      exp_t e;
      e.gnt = 4'b0001; e.cmd = 2'b01; e.addr = 8'h99; e.fetch = '0; e.inv = '0;
      e.wb = 1'b0; e.wd = 0; e.fd = 100000;
      exp_q.push_back(e);
      model_last = 0;
      bus.req = 4'b0001; bus.reqCmd = 8'b0000_0001; bus.reqAddr = 32'h00000099;
      bus.ownerModified = '0;
      ok = 1'b0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (bus.memReq) begin
          ok = 1'b1;
          break;
        end
      end
      check("fill_reached", 32'(ok), 32'd1);
      rst = 1'b1;
      bus.req = '0;
      @(negedge clk);
      exp_q.delete();
      model_last = N - 1;
      rst = 1'b0;
      check("rstfill_memreq", 32'(bus.memReq), 32'd0);
      check("rstfill_grant",  32'(bus.grant), 32'd0);
      check("rstfill_done",   32'(bus.done), 32'd0);
      repeat (4) @(negedge clk);
      issue(4'b1111, 8'hFF, 32'h0D0C0B0A, 4'b0000, 0, 0, 1'b0);
    end

    // Randomized traffic, including invalid patterns and mid-transaction drops.
    for (int n = 0; n < 80; n++) begin
      logic [N-1:0]        r;
      logic [2*N-1:0]      c;
      logic [N*ADDR_W-1:0] a;
      logic [N-1:0]        om;
      r  = N'($urandom);
      c  = (2*N)'($urandom);
      a  = (N*ADDR_W)'($urandom);
      om = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      issue(r, c, a, om, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            1'($urandom_range(0, 3) == 0));
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
